// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_mp
//  Description : Multi-read-port register file. It sweeps itself to zero
//                after reset. Entry 0 always reads 0. Reads are combinational.
//                Defining REGFILE_BYPASS_EN forwards same-cycle write data to
//                a read port that addresses the entry being written.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NREAD*ADDR_W-1:0] ReadReg,
    output logic [NREAD*DATA_W-1:0] ReadData,
    input  logic [ADDR_W-1:0]       WriteReg,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic                    RegWrite,
    output logic                    Ready
);

    localparam int                c_DEPTH       = 2 ** ADDR_W;
    localparam logic [0:0]        c_STATE_CLEAR = 1'b0;
    localparam logic [0:0]        c_STATE_READY = 1'b1;
    localparam logic [ADDR_W-1:0] c_FIRST_IDX   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_LAST_IDX    = ADDR_W'(c_DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clrPtr;
    logic              w_writeEn;
    logic [DATA_W-1:0] w_entry [c_DEPTH];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= c_STATE_CLEAR;
            r_clrPtr <= c_FIRST_IDX;
        end else if (r_state == c_STATE_CLEAR) begin
            r_clrPtr <= r_clrPtr + ADDR_W'(1);
            if (r_clrPtr == c_LAST_IDX) begin
                r_state <= c_STATE_READY;
            end
        end
    end

    assign Ready     = (r_state == c_STATE_READY);
    assign w_writeEn = Ready && RegWrite && (WriteReg != '0);

    // Entry 0 has no storage; the sweep therefore only visits 1..DEPTH-1.
    for (genvar i = 0; i < c_DEPTH; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign w_entry[i] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    r_q <= r_q;
                end else if ((r_state == c_STATE_CLEAR) && (r_clrPtr == ADDR_W'(i))) begin
                    r_q <= '0;
                end else if (w_writeEn && (WriteReg == ADDR_W'(i))) begin
                    r_q <= WriteData;
                end
            end
            assign w_entry[i] = r_q;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rdPort
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        assign w_addr = ReadReg[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign w_data = (w_writeEn && (WriteReg == w_addr)) ? WriteData : w_entry[w_addr];
`else
        assign w_data = w_entry[w_addr];
`endif
        assign ReadData[p*DATA_W +: DATA_W] = Ready ? w_data : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_mp
//  Description : Self-checking bench for register_file_mp (32x32, 2 read ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic [NR*AW-1:0] ReadReg;
    logic [NR*DW-1:0] ReadData;
    logic [AW-1:0]    WriteReg;
    logic [DW-1:0]    WriteData;
    logic             RegWrite;
    logic             Ready;

    always #5 Clk = ~Clk;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ReadReg   (ReadReg),
        .ReadData  (ReadData),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Ready     (Ready)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: array contents, a ready flag and a count of sweep cycles.
    logic [DW-1:0] mMem [DEPTH];
    bit            mReady = 1'b0;
    int            mSweep = 0;
    bit            chkOn  = 1'b0;

    logic          aReady;
    logic [DW-1:0] aRd0, aRd1;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] e0, e1;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (!mReady) return '0;
        if (BYP && RegWrite && (WriteReg != '0) && (WriteReg == a)) return WriteData;
        return mMem[a];
    endfunction

    // One clock cycle: drive at negedge, sample/check before the edge, then
    // advance the model with the inputs the DUT saw at the rising edge.
    task automatic drive(input logic rn, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra0,
                         input logic [AW-1:0] ra1);
        @(negedge Clk);
        Reset_n   = rn;
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg   = {ra1, ra0};
        #1;
        aReady = Ready;
        aRd0   = ReadData[DW-1:0];
        aRd1   = ReadData[2*DW-1:DW];
        if (chkOn) begin
            chk("mdlReady", {31'd0, aReady}, {31'd0, mReady});
            chk("mdlRd0", aRd0, expRead(ra0));
            chk("mdlRd1", aRd1, expRead(ra1));
        end
        @(posedge Clk);
        if (!rn) begin
            mReady = 1'b0;
            mSweep = 0;
        end else if (!mReady) begin
            mSweep++;
            if (mSweep == DEPTH - 1) begin
                mReady = 1'b1;
                for (int k = 0; k < DEPTH; k++) mMem[k] = '0;
            end
        end else if (we && (wa != '0)) begin
            mMem[wa] = wd;
        end
    endtask

    // Counts idle cycles sampled with Ready=0 before Ready rises (bounded).
    task automatic waitSweep(input string name, input int expN);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b0, '0, '0, '0, '0);
            if (aReady) break;
            n++;
        end
        chk(name, n, expN);
    endtask

    initial begin
        Reset_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0; ReadReg = '0;
        for (int k = 0; k < DEPTH; k++) mMem[k] = '0;

        // Power-up reset, two cycles low
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        chkOn = 1'b1;
        drive(1'b0, 1'b1, 5'd4, 32'h1111_1111, 5'd4, 5'd0);
        chk("rstReady", {31'd0, aReady}, 32'd0);
        waitSweep("initSweepLen", 31);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, '0, '0, 5'(a), 5'(31 - a));
            chk("initZero0", aRd0, 32'd0);
            chk("initZero1", aRd1, 32'd0);
        end

        // Directed vectors, each row one cycle in READY
        tbl[0] = '{1'b1, 5'd0,  32'd10,        5'd0,  5'd0,  32'd0, 32'd0};
        tbl[1] = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd0,  32'd0, 32'd0};
        tbl[2] = '{1'b1, 5'd1,  32'd11,        5'd1,  5'd1,  BYP ? 32'd11 : 32'd0, BYP ? 32'd11 : 32'd0};
        tbl[3] = '{1'b0, 5'd0,  32'd0,         5'd1,  5'd1,  32'd11, 32'd11};
        tbl[4] = '{1'b1, 5'd7,  32'h1234,      5'd7,  5'd1,  BYP ? 32'h1234 : 32'd0, 32'd11};
        tbl[5] = '{1'b0, 5'd0,  32'd0,         5'd7,  5'd7,  32'h1234, 32'h1234};
        tbl[6] = '{1'b1, 5'd7,  32'hAAAA,      5'd7,  5'd0,  BYP ? 32'hAAAA : 32'h1234, 32'd0};
        tbl[7] = '{1'b0, 5'd0,  32'd0,         5'd7,  5'd31, 32'hAAAA, 32'd0};
        tbl[8] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd30, 5'd31, 32'd0, BYP ? 32'hFFFF_FFFF : 32'd0};
        tbl[9] = '{1'b0, 5'd0,  32'd0,         5'd31, 5'd7,  32'hFFFF_FFFF, 32'hAAAA};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1);
            chk("tblRd0", aRd0, tbl[i].e0);
            chk("tblRd1", aRd1, tbl[i].e1);
        end

        // Reset in READY with a same-cycle write, then full resweep
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        drive(1'b0, 1'b1, 5'd5, 32'h5555, 5'd7, 5'd5);
        waitSweep("resweepLen", 31);
        drive(1'b1, 1'b0, '0, '0, 5'd7, 5'd5);
        chk("resweep7", aRd0, 32'd0);
        chk("resweep5", aRd1, 32'd0);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(63, 0) != 0), 1'($urandom), 5'($urandom_range(31, 0)),
                  $urandom, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        end
        for (int k = 0; k < 40 && !mReady; k++) drive(1'b1, 1'b0, '0, '0, '0, '0);

        // Write during the sweep is ignored
        drive(1'b1, 1'b1, 5'd3, 32'hBEEF, 5'd3, 5'd3);
        drive(1'b1, 1'b0, '0, '0, 5'd3, 5'd0);
        chk("preClr3", aRd0, 32'hBEEF);
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, '0, '0, 5'd3, 5'd3);
        drive(1'b1, 1'b1, 5'd3, 32'hDEAD, 5'd3, 5'd3);
        waitSweep("sweepAfterWr", 25);
        drive(1'b1, 1'b0, '0, '0, 5'd3, 5'd3);
        chk("clrWr3", aRd0, 32'd0);

        // Reset pulse mid-sweep restarts the full sweep
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 15; k++) drive(1'b1, 1'b0, '0, '0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        waitSweep("midSweepRst", 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
